// File: rtl/bsg_manycore_dma_pkg.sv
// Shared enums and packet constants for the manycore scatter DMA engine.
package bsg_manycore_dma_pkg;

    typedef enum logic [3:0] {
        CSR_CMD      = 4'd0,
        CSR_STATUS   = 4'd1,
        CSR_SRC_IDX  = 4'd2,
        CSR_DST_ADDR = 4'd3,
        CSR_DST_CORD = 4'd4,
        CSR_DIM1     = 4'd5,
        CSR_SKIP2    = 4'd6,
        CSR_DIM2     = 4'd7,
        CSR_SIG_ADDR = 4'd8,
        CSR_SIG_CORD = 4'd9,
        CSR_NUM      = 4'd10
    } csr_idx_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_SEND      = 3'd2,
        S_DRAIN     = 3'd3,
        S_SIGNAL    = 3'd4,
        S_SIG_DRAIN = 3'd5
    } dma_state_e;

    localparam logic [1:0] OP_REMOTE_STORE = 2'b01;

endpackage

// File: rtl/bsg_manycore_dma_2d_addr_gen.sv
// Row/column walker for a 2D transfer: produces the staging-buffer index and
// destination word address of the current element, plus a last-element flag.
module bsg_manycore_dma_2d_addr_gen #(
    parameter int unsigned cnt_width_p  = 32,
    parameter int unsigned idx_width_p  = 4,
    parameter int unsigned addr_width_p = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_step,
    input  logic [idx_width_p-1:0]  i_src_idx,
    input  logic [cnt_width_p-1:0]  i_n1,
    input  logic [cnt_width_p-1:0]  i_n2,
    input  logic [addr_width_p-1:0] i_dst_word,
    input  logic [addr_width_p-1:0] i_skip_word,
    output logic [idx_width_p-1:0]  o_buf_idx,
    output logic [addr_width_p-1:0] o_dst_word,
    output logic                    o_last
);

    logic [cnt_width_p-1:0]  r_col;
    logic [cnt_width_p-1:0]  r_row;
    logic [idx_width_p-1:0]  r_row_idx;
    logic [addr_width_p-1:0] r_row_dst;
    logic                    w_col_last;
    logic                    w_row_last;

    assign w_col_last = (r_col + cnt_width_p'(1)) == i_n1;
    assign w_row_last = (r_row + cnt_width_p'(1)) == i_n2;
    assign o_last     = w_col_last && w_row_last;

    // Row bases advance incrementally so no multiplier is needed; the index
    // wraps naturally modulo the buffer depth.
    assign o_buf_idx  = r_row_idx + idx_width_p'(r_col);
    assign o_dst_word = r_row_dst + addr_width_p'(r_col);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_row_idx <= '0;
            r_row_dst <= '0;
        end else if (i_start) begin
            r_col     <= '0;
            r_row     <= '0;
            r_row_idx <= i_src_idx;
            r_row_dst <= i_dst_word;
        end else if (i_step) begin
            if (w_col_last) begin
                r_col     <= '0;
                r_row     <= r_row + cnt_width_p'(1);
                r_row_idx <= r_row_idx + idx_width_p'(i_n1);
                r_row_dst <= r_row_dst + i_skip_word;
            end else begin
                r_col <= r_col + cnt_width_p'(1);
            end
        end
    end

endmodule

// File: rtl/bsg_manycore_scatter_dma.sv
// Tile-side scatter DMA: streams the local staging buffer to a 2D-strided
// remote destination, then posts a completion store to a signal address.
module bsg_manycore_scatter_dma
    import bsg_manycore_dma_pkg::*;
#(
    parameter int unsigned x_cord_width_p    = 4,
    parameter int unsigned y_cord_width_p    = 4,
    parameter int unsigned dmem_size_p       = 16,
    parameter int unsigned data_width_p      = 32,
    parameter int unsigned addr_width_p      = 32,
    parameter int unsigned load_id_width_p   = 11,
    parameter int unsigned max_out_credits_p = 200,
    localparam int unsigned mask_width_lp    = data_width_p / 8,
    localparam int unsigned credit_width_lp  = $clog2(max_out_credits_p + 1),
    localparam int unsigned packet_width_lp  = addr_width_p + 2 + mask_width_lp + load_id_width_p
                                             + data_width_p + 2 * x_cord_width_p + 2 * y_cord_width_p
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       in_v_i,
    output logic                       in_yumi_o,
    input  logic [addr_width_p-1:0]    in_addr_i,
    input  logic [data_width_p-1:0]    in_data_i,
    input  logic [mask_width_lp-1:0]   in_mask_i,
    input  logic                       in_we_i,
    output logic                       returning_v_o,
    output logic [data_width_p-1:0]    returning_data_o,
    output logic                       out_v_o,
    output logic [packet_width_lp-1:0] out_packet_o,
    input  logic                       out_ready_i,
    input  logic [credit_width_lp-1:0] out_credits_i,
    input  logic [x_cord_width_p-1:0]  my_x_i,
    input  logic [y_cord_width_p-1:0]  my_y_i
);

    localparam int unsigned idx_width_lp = $clog2(dmem_size_p);

    typedef struct packed {
        logic [addr_width_p-1:0]    addr;
        logic [1:0]                 op;
        logic [mask_width_lp-1:0]   op_ex;
        logic [load_id_width_p-1:0] reg_id;
        logic [data_width_p-1:0]    payload;
        logic [y_cord_width_p-1:0]  src_y_cord;
        logic [x_cord_width_p-1:0]  src_x_cord;
        logic [y_cord_width_p-1:0]  y_cord;
        logic [x_cord_width_p-1:0]  x_cord;
    } packet_s;

    dma_state_e              r_state;
    logic                    r_out_v;
    logic                    r_err;
    logic                    r_ret_v;
    packet_s                 r_pkt;
    logic [data_width_p-1:0] r_ret_data;
    logic [data_width_p-1:0] r_src_idx, r_dst_addr, r_dst_cord, r_dim1;
    logic [data_width_p-1:0] r_skip2, r_dim2, r_sig_addr, r_sig_cord;
    logic [data_width_p-1:0] r_mem [dmem_size_p];

    logic                    w_is_csr, w_is_buf, w_wr, w_rd, w_cmd, w_busy;
    logic                    w_start, w_step, w_last, w_zero_len, w_credits_full;
    csr_idx_e                w_csr;
    logic [idx_width_lp-1:0] w_buf_idx, w_eng_idx;
    logic [addr_width_p-1:0] w_dst_word;
    logic [data_width_p-1:0] w_n1, w_csr_rdata;
    packet_s                 w_store_pkt, w_sig_pkt;

    assign w_is_csr  = in_addr_i < addr_width_p'(CSR_NUM);
    assign w_is_buf  = (in_addr_i >> idx_width_lp) == addr_width_p'(1);
    assign w_buf_idx = in_addr_i[idx_width_lp-1:0];
    assign w_csr     = csr_idx_e'(in_addr_i[3:0]);
    assign w_busy    = r_state != S_IDLE;

    // Remote buffer traffic yields the single read port to the engine.
    assign in_yumi_o = in_v_i && !(w_is_buf && (r_state == S_READ));
    assign w_wr      = in_yumi_o && in_we_i;
    assign w_rd      = in_yumi_o && !in_we_i;
    assign w_cmd     = w_wr && w_is_csr && (w_csr == CSR_CMD);

    assign w_n1           = r_dim1 >> 2;
    assign w_zero_len     = (w_n1 == '0) || (r_dim2 == '0);
    assign w_start        = w_cmd && !w_busy;
    assign w_step         = (r_state == S_SEND) && out_ready_i;
    assign w_credits_full = out_credits_i == credit_width_lp'(max_out_credits_p);

    bsg_manycore_dma_2d_addr_gen #(
        .cnt_width_p  (data_width_p),
        .idx_width_p  (idx_width_lp),
        .addr_width_p (addr_width_p)
    ) u_addr_gen (
        .i_clk       (clk_i),
        .i_rst_n     (reset_n_i),
        .i_start     (w_start),
        .i_step      (w_step),
        .i_src_idx   (r_src_idx[idx_width_lp-1:0]),
        .i_n1        (w_n1),
        .i_n2        (r_dim2),
        .i_dst_word  (addr_width_p'(r_dst_addr >> 2)),
        .i_skip_word (addr_width_p'(r_skip2 >> 2)),
        .o_buf_idx   (w_eng_idx),
        .o_dst_word  (w_dst_word),
        .o_last      (w_last)
    );

    always_comb begin
        w_csr_rdata = '0;
        if (w_is_csr) begin
            case (w_csr)
                CSR_STATUS:   w_csr_rdata = data_width_p'({r_err, w_busy});
                CSR_SRC_IDX:  w_csr_rdata = r_src_idx;
                CSR_DST_ADDR: w_csr_rdata = r_dst_addr;
                CSR_DST_CORD: w_csr_rdata = r_dst_cord;
                CSR_DIM1:     w_csr_rdata = r_dim1;
                CSR_SKIP2:    w_csr_rdata = r_skip2;
                CSR_DIM2:     w_csr_rdata = r_dim2;
                CSR_SIG_ADDR: w_csr_rdata = r_sig_addr;
                CSR_SIG_CORD: w_csr_rdata = r_sig_cord;
                default:      w_csr_rdata = '0;
            endcase
        end
    end

    // Payload is filled from the buffer read port when the packet is registered.
    always_comb begin
        w_store_pkt            = '0;
        w_store_pkt.addr       = w_dst_word;
        w_store_pkt.op         = OP_REMOTE_STORE;
        w_store_pkt.op_ex      = '1;
        w_store_pkt.src_y_cord = my_y_i;
        w_store_pkt.src_x_cord = my_x_i;
        w_store_pkt.y_cord     = r_dst_cord[16 +: y_cord_width_p];
        w_store_pkt.x_cord     = r_dst_cord[x_cord_width_p-1:0];

        w_sig_pkt              = w_store_pkt;
        w_sig_pkt.addr         = addr_width_p'(r_sig_addr >> 2);
        w_sig_pkt.payload      = data_width_p'(1);
        w_sig_pkt.y_cord       = r_sig_cord[16 +: y_cord_width_p];
        w_sig_pkt.x_cord       = r_sig_cord[x_cord_width_p-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (w_wr && w_is_buf) begin
            for (int b = 0; b < int'(mask_width_lp); b++) begin
                if (in_mask_i[b]) r_mem[w_buf_idx][8*b +: 8] <= in_data_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_src_idx  <= '0;
            r_dst_addr <= '0;
            r_dst_cord <= '0;
            r_dim1     <= '0;
            r_skip2    <= '0;
            r_dim2     <= '0;
            r_sig_addr <= '0;
            r_sig_cord <= '0;
        end else if (w_wr && w_is_csr) begin
            case (w_csr)
                CSR_SRC_IDX:  r_src_idx  <= in_data_i;
                CSR_DST_ADDR: r_dst_addr <= in_data_i;
                CSR_DST_CORD: r_dst_cord <= in_data_i;
                CSR_DIM1:     r_dim1     <= in_data_i;
                CSR_SKIP2:    r_skip2    <= in_data_i;
                CSR_DIM2:     r_dim2     <= in_data_i;
                CSR_SIG_ADDR: r_sig_addr <= in_data_i;
                CSR_SIG_CORD: r_sig_cord <= in_data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_ret_v    <= 1'b0;
            r_ret_data <= '0;
        end else begin
            r_ret_v <= w_rd;
            if (w_rd) r_ret_data <= w_is_buf ? r_mem[w_buf_idx] : w_csr_rdata;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
            r_out_v <= 1'b0;
            r_err   <= 1'b0;
            r_pkt   <= '0;
        end else begin
            if (w_cmd && w_busy) begin
                r_err <= 1'b1;
            end else if (w_wr && w_is_csr && (w_csr == CSR_STATUS)) begin
                r_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_cmd) r_state <= w_zero_len ? S_DRAIN : S_READ;
                end
                S_READ: begin
                    r_pkt         <= w_store_pkt;
                    r_pkt.payload <= r_mem[w_eng_idx];
                    r_out_v       <= 1'b1;
                    r_state       <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready_i) begin
                        r_out_v <= 1'b0;
                        r_state <= w_last ? S_DRAIN : S_READ;
                    end
                end
                S_DRAIN: begin
                    if (w_credits_full) begin
                        r_pkt   <= w_sig_pkt;
                        r_out_v <= 1'b1;
                        r_state <= S_SIGNAL;
                    end
                end
                S_SIGNAL: begin
                    if (out_ready_i) begin
                        r_out_v <= 1'b0;
                        r_state <= S_SIG_DRAIN;
                    end
                end
                S_SIG_DRAIN: begin
                    if (w_credits_full) r_state <= S_IDLE;
                end
                default: begin
                    r_out_v <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_v_o          = r_out_v;
    assign out_packet_o     = r_pkt;
    assign returning_v_o    = r_ret_v;
    assign returning_data_o = r_ret_data;

endmodule

// File: tb/tb_bsg_manycore_scatter_dma.sv
// Directed bench for the scatter DMA: CSR/buffer access, 2D geometry, wrap,
// backpressure, credit drain, zero length, busy CMD and mid-transfer reset.
module tb_bsg_manycore_scatter_dma;

    localparam int unsigned XW   = 4;
    localparam int unsigned YW   = 4;
    localparam int unsigned DMEM = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 32;
    localparam int unsigned LW   = 11;
    localparam int unsigned MAXC = 200;
    localparam int unsigned CW   = $clog2(MAXC + 1);
    localparam int unsigned PW   = AW + 2 + DW / 8 + LW + DW + 2 * XW + 2 * YW;

    localparam logic [31:0] A_CMD = 0, A_STATUS = 1, A_SRC = 2, A_DST = 3, A_DCORD = 4;
    localparam logic [31:0] A_DIM1 = 5, A_SKIP2 = 6, A_DIM2 = 7, A_SIG = 8, A_SCORD = 9;
    localparam logic [XW-1:0] MY_X = 4'd1;
    localparam logic [YW-1:0] MY_Y = 4'd2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_v, in_we, in_yumi_o;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic [3:0]    in_mask;
    logic          returning_v_o;
    logic [DW-1:0] returning_data_o;
    logic          out_v_o, out_ready;
    logic [PW-1:0] out_packet_o;
    logic [CW-1:0] out_credits;

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] pkt_q[$];

    always #5 clk = ~clk;

    bsg_manycore_scatter_dma #(
        .x_cord_width_p(XW), .y_cord_width_p(YW), .dmem_size_p(DMEM),
        .data_width_p(DW), .addr_width_p(AW), .load_id_width_p(LW),
        .max_out_credits_p(MAXC)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .in_v_i(in_v), .in_yumi_o(in_yumi_o), .in_addr_i(in_addr),
        .in_data_i(in_data), .in_mask_i(in_mask), .in_we_i(in_we),
        .returning_v_o(returning_v_o), .returning_data_o(returning_data_o),
        .out_v_o(out_v_o), .out_packet_o(out_packet_o), .out_ready_i(out_ready),
        .out_credits_i(out_credits), .my_x_i(MY_X), .my_y_i(MY_Y)
    );

    // Inputs change 1 ns after posedge, so a negedge sample sees what the next edge uses.
    always @(negedge clk) if (reset_n && out_v_o && out_ready) pkt_q.push_back(out_packet_o);

    function automatic logic [31:0] f_addr(input logic [PW-1:0] p); return p[PW-1 -: AW]; endfunction
    function automatic logic [31:0] f_pay (input logic [PW-1:0] p); return p[16 +: DW];   endfunction
    function automatic logic [1:0]  f_op  (input logic [PW-1:0] p); return p[PW-AW-1 -: 2]; endfunction
    function automatic logic [3:0]  f_opex(input logic [PW-1:0] p); return p[PW-AW-3 -: 4]; endfunction
    function automatic logic [15:0] f_cord(input logic [PW-1:0] p); return p[15:0]; endfunction

    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] rdata);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_v = 1'b1; in_we = we; in_addr = addr; in_data = data; in_mask = 4'hf;
        @(negedge clk);
        while (!in_yumi_o && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!in_yumi_o) begin errors++; $display("FAIL bus_accept addr=%h yumi=0 required=1", addr); end
        @(posedge clk); #1;
        in_v = 1'b0; in_we = 1'b0;
        @(negedge clk);
        rdata = returning_data_o;
        checks++;
        if (returning_v_o !== !we)
            begin errors++; $display("FAIL returning_v addr=%h got=%b required=%b", addr, returning_v_o, !we); end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        bus(1'b1, addr, data, d);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus(1'b0, addr, 32'h0, data);
    endtask

    task automatic wait_pkts(input int n, input int limit, output bit ok);
        int c;
        c = 0;
        while (pkt_q.size() < n && c < limit) begin @(negedge clk); c++; end
        ok = pkt_q.size() >= n;
    endtask

    task automatic wait_idle(output bit ok);
        logic [31:0] d;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            rd(A_STATUS, d);
            if (d[0] == 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0; in_v = 1'b0; in_we = 1'b0; in_addr = '0; in_data = '0; in_mask = '0;
        out_ready = 1'b1; out_credits = CW'(MAXC);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_v_o !== 1'b0 || returning_v_o !== 1'b0 || in_yumi_o !== 1'b0)
            begin errors++; $display("FAIL reset_outputs got=%b%b%b required=000", out_v_o, returning_v_o, in_yumi_o); end
        @(posedge clk); #1 reset_n = 1'b1;
        rd(A_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got=%h required=0", d); end
        rd(A_DST, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_dst_addr got=%h required=0", d); end
    endtask

    task automatic test_contiguous();
        logic [31:0] d;
        bit ok;
        for (int i = 0; i < 4; i++) wr(DMEM + i, 32'hA000_0000 + i);
        wr(A_SRC, 0); wr(A_DST, 32'h100); wr(A_DCORD, 32'h0002_0003);
        wr(A_DIM1, 16); wr(A_DIM2, 1); wr(A_SKIP2, 0);
        wr(A_SIG, 32'h200); wr(A_SCORD, 32'h0006_0005);
        pkt_q.delete();
        wr(A_CMD, 1);
        rd(A_STATUS, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL contig_busy got=%h required=1", d); end
        wait_pkts(5, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL contig_timeout got=%0d pkts required=5", pkt_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (f_addr(pkt_q[i]) !== 32'h40 + i || f_pay(pkt_q[i]) !== 32'hA000_0000 + i)
                begin errors++; $display("FAIL contig_store%0d got=%h/%h required=%h/%h", i,
                      f_addr(pkt_q[i]), f_pay(pkt_q[i]), 32'h40 + i, 32'hA000_0000 + i); end
        end
        checks++;
        if (f_op(pkt_q[0]) !== 2'b01 || f_opex(pkt_q[0]) !== 4'hf || f_cord(pkt_q[0]) !== 16'h2123)
            begin errors++; $display("FAIL contig_fields got op=%b ex=%h cord=%h required op=01 ex=f cord=2123",
                  f_op(pkt_q[0]), f_opex(pkt_q[0]), f_cord(pkt_q[0])); end
        checks++;
        if (f_addr(pkt_q[4]) !== 32'h80 || f_pay(pkt_q[4]) !== 32'h1 || f_cord(pkt_q[4]) !== 16'h2165)
            begin errors++; $display("FAIL contig_signal got=%h/%h/%h required=80/1/2165",
                  f_addr(pkt_q[4]), f_pay(pkt_q[4]), f_cord(pkt_q[4])); end
        wait_idle(ok);
        rd(A_STATUS, d);
        checks++; if (d !== 32'h0 || pkt_q.size() != 5)
            begin errors++; $display("FAIL contig_done status=%h pkts=%0d required=0/5", d, pkt_q.size()); end
        rd(DMEM, d);
        checks++; if (d !== 32'hA000_0000) begin errors++; $display("FAIL buf_readback got=%h required=a0000000", d); end
        rd(12, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_load got=%h required=0", d); end
        rd(A_DST, d);
        checks++; if (d !== 32'h100) begin errors++; $display("FAIL csr_readback got=%h required=100", d); end
    endtask

    task automatic test_2d();
        logic [31:0] exp_addr [6];
        bit ok;
        exp_addr = '{32'h0, 32'h1, 32'h10, 32'h11, 32'h20, 32'h21};
        for (int i = 0; i < 6; i++) wr(DMEM + i, 32'hB000_0000 + i);
        wr(A_SRC, 0); wr(A_DST, 0); wr(A_DIM1, 8); wr(A_DIM2, 3); wr(A_SKIP2, 32'h40);
        pkt_q.delete();
        wr(A_CMD, 1);
        wait_pkts(7, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL 2d_timeout got=%0d pkts required=7", pkt_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (f_addr(pkt_q[i]) !== exp_addr[i] || f_pay(pkt_q[i]) !== 32'hB000_0000 + i)
                begin errors++; $display("FAIL 2d_store%0d got=%h/%h required=%h/%h", i,
                      f_addr(pkt_q[i]), f_pay(pkt_q[i]), exp_addr[i], 32'hB000_0000 + i); end
        end
        checks++; if (f_addr(pkt_q[6]) !== 32'h80) begin errors++; $display("FAIL 2d_signal got=%h required=80", f_addr(pkt_q[6])); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL 2d_idle got=busy required=idle"); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_idx [4];
        bit ok;
        exp_idx = '{32'd14, 32'd15, 32'd0, 32'd1};
        for (int i = 0; i < 16; i++) wr(DMEM + i, 32'hC000_0000 + i);
        wr(A_SRC, 14); wr(A_DST, 32'h400); wr(A_DIM1, 16); wr(A_DIM2, 1);
        pkt_q.delete();
        wr(A_CMD, 1);
        wait_pkts(5, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got=%0d pkts required=5", pkt_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (f_addr(pkt_q[i]) !== 32'h100 + i || f_pay(pkt_q[i]) !== 32'hC000_0000 + exp_idx[i])
                begin errors++; $display("FAIL wrap_store%0d got=%h/%h required=%h/%h", i,
                      f_addr(pkt_q[i]), f_pay(pkt_q[i]), 32'h100 + i, 32'hC000_0000 + exp_idx[i]); end
        end
        wait_idle(ok);
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] held;
        bit ok;
        int n, bad;
        wr(A_SRC, 0); wr(A_DST, 32'h100); wr(A_DIM1, 8); wr(A_DIM2, 1);
        @(posedge clk); #1 out_ready = 1'b0;
        pkt_q.delete();
        wr(A_CMD, 1);
        n = 0;
        while (!out_v_o && n < 20) begin @(negedge clk); n++; end
        held = out_packet_o;
        checks++;
        if (out_v_o !== 1'b1 || f_addr(held) !== 32'h40 || f_pay(held) !== 32'hC000_0000)
            begin errors++; $display("FAIL bp_first got=%b/%h/%h required=1/40/c0000000", out_v_o, f_addr(held), f_pay(held)); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_v_o !== 1'b1 || out_packet_o !== held)
                begin errors++; $display("FAIL bp_stable cycle %0d got v=%b addr=%h required v=1 addr=%h",
                      i, out_v_o, f_addr(out_packet_o), f_addr(held)); end
        end
        @(posedge clk); #1 out_credits = CW'(MAXC - 1); out_ready = 1'b1;
        wait_pkts(2, 50, ok);
        checks++;
        if (!ok || pkt_q[0] !== held || f_addr(pkt_q[1]) !== 32'h41 || f_pay(pkt_q[1]) !== 32'hC000_0001)
            begin errors++; $display("FAIL bp_stores got=%0d pkts addr1=%h required=2 pkts addr1=41", pkt_q.size(), f_addr(pkt_q[1])); end
        bad = 0;
        repeat (10) begin @(negedge clk); if (out_v_o) bad++; end
        checks++;
        if (bad != 0 || pkt_q.size() != 2)
            begin errors++; $display("FAIL credit_wait got=%0d valid cycles %0d pkts required=0/2", bad, pkt_q.size()); end
        @(posedge clk); #1 out_credits = CW'(MAXC);
        wait_pkts(3, 50, ok);
        checks++;
        if (!ok || f_addr(pkt_q[2]) !== 32'h80 || f_pay(pkt_q[2]) !== 32'h1)
            begin errors++; $display("FAIL credit_signal got=%0d pkts addr=%h required=3 pkts addr=80", pkt_q.size(), f_addr(pkt_q[2])); end
        wait_idle(ok);
    endtask

    task automatic test_zero_len();
        bit ok;
        wr(A_DIM1, 16); wr(A_DIM2, 0);
        pkt_q.delete();
        wr(A_CMD, 1);
        wait_idle(ok);
        checks++;
        if (!ok || pkt_q.size() != 1 || f_addr(pkt_q[0]) !== 32'h80 || f_pay(pkt_q[0]) !== 32'h1)
            begin errors++; $display("FAIL zero_len got=%0d pkts addr=%h required=1 pkt addr=80", pkt_q.size(), f_addr(pkt_q[0])); end
    endtask

    task automatic test_cmd_busy_reset();
        logic [31:0] d;
        int n;
        wr(A_SRC, 0); wr(A_DIM1, 16); wr(A_DIM2, 1);
        @(posedge clk); #1 out_ready = 1'b0;
        pkt_q.delete();
        wr(A_CMD, 1);
        wr(A_CMD, 1);
        rd(A_STATUS, d);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL cmd_busy_status got=%h required=3", d); end
        wr(A_STATUS, 32'hFFFF_FFFF);
        rd(A_STATUS, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL status_clear got=%h required=1", d); end
        n = 0;
        while (!out_v_o && n < 20) begin @(negedge clk); n++; end
        checks++; if (out_v_o !== 1'b1) begin errors++; $display("FAIL send_stall got v=%b required=1", out_v_o); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_v_o !== 1'b0) begin errors++; $display("FAIL reset_async got v=%b required=0", out_v_o); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1; out_ready = 1'b1;
        for (int k = 1; k < 10; k++) begin
            rd(k, d);
            checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_csr%0d got=%h required=0", k, d); end
        end
        repeat (5) @(negedge clk);
        checks++; if (pkt_q.size() != 0) begin errors++; $display("FAIL post_reset_pkts got=%0d required=0", pkt_q.size()); end
    endtask

    initial begin
        test_reset();
        test_contiguous();
        test_2d();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_cmd_busy_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before test sequence completed");
        $fatal(1);
    end

endmodule
